// File: rtl/sid_regfile_8580.sv
// sid_regfile_8580: CPU-side register file for one 8580 SID.
// Decodes the 32-byte SID window, holds voice/filter control registers,
// returns paddle / voice-3 values on reads and models the decaying
// data-bus latch seen when reading write-only registers.
module sid_regfile_8580 #(
  parameter logic [19:0] DECAY_CYCLES = 20'd350000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [23:0] freq_lo,
  output logic [23:0] freq_hi,
  output logic [23:0] pw_lo,
  output logic [23:0] pw_hi,
  output logic [23:0] control,
  output logic [23:0] att_dec,
  output logic [23:0] sus_rel,
  output logic [7:0]  fc_lo,
  output logic [7:0]  fc_hi,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  input  logic [7:0]  pot_x,
  input  logic [7:0]  pot_y,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3
);

  localparam int NUM_REGS = 25;  // writable offsets 0x00..0x18

  logic [NUM_REGS-1:0][7:0] r_regs;
  logic [7:0]               r_bus_latch;
  logic [19:0]              r_decay_cnt;

  logic       w_wr;
  logic       w_rd;
  logic       w_ro_addr;
  logic [7:0] w_ro_val;
  logic [7:0] w_wr_val;

  // Access decode, read-only source mux and write-data masking.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_wr      = cs && we;
    w_rd      = cs && !we;
    w_ro_addr = 1'b0;
    w_ro_val  = 8'h00;
    w_wr_val  = data_in;
    case (addr)
      5'h19: begin w_ro_addr = 1'b1; w_ro_val = pot_x; end
      5'h1A: begin w_ro_addr = 1'b1; w_ro_val = pot_y; end
      5'h1B: begin w_ro_addr = 1'b1; w_ro_val = osc3;  end
      5'h1C: begin w_ro_addr = 1'b1; w_ro_val = env3;  end
      default: ;
    endcase
    case (addr)
      5'h03, 5'h0A, 5'h11: w_wr_val = {4'h0, data_in[3:0]};  // pw_hi is 12-bit PW
      5'h15:               w_wr_val = {5'h00, data_in[2:0]}; // fc_lo is 3 bits
      default: ;
    endcase
  end

  // Register array: stores masked write data at 0x00..0x18.
  // NOTE: the array is small and its contents are visible outputs, so it is
  // reset like any other flop rather than left as an unreset memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_regs <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // sees pre-edge values regardless of statement order.
        if (addr == 5'(i)) r_regs[i] <= w_wr_val;
      end
    end
  end

  // Bus latch and idle counter: refreshed by any write or read-only read,
  // otherwise ages on ce_1m and clears once the counter has saturated.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bus_latch <= 8'h00;
      r_decay_cnt <= '0;
    end else if (w_wr) begin
      r_bus_latch <= data_in;
      r_decay_cnt <= '0;
    end else if (w_rd && w_ro_addr) begin
      r_bus_latch <= w_ro_val;
      r_decay_cnt <= '0;
    end else if (ce_1m) begin
      if (r_decay_cnt != DECAY_CYCLES) r_decay_cnt <= r_decay_cnt + 20'd1;
      else                             r_bus_latch <= 8'h00;
    end
  end

  // Registered read data: live input for read-only offsets, else the latch
  // value as it stood before this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= 8'h00;
    end else if (w_rd) begin
      data_out <= w_ro_addr ? w_ro_val : r_bus_latch;
    end
  end

  // Voice n field byte lives at offset 7n + k; voice n drives bits [8n+7:8n].
  assign freq_lo  = {r_regs[14], r_regs[7],  r_regs[0]};
  assign freq_hi  = {r_regs[15], r_regs[8],  r_regs[1]};
  assign pw_lo    = {r_regs[16], r_regs[9],  r_regs[2]};
  assign pw_hi    = {r_regs[17], r_regs[10], r_regs[3]};
  assign control  = {r_regs[18], r_regs[11], r_regs[4]};
  assign att_dec  = {r_regs[19], r_regs[12], r_regs[5]};
  assign sus_rel  = {r_regs[20], r_regs[13], r_regs[6]};
  assign fc_lo    = r_regs[21];
  assign fc_hi    = r_regs[22];
  assign res_filt = r_regs[23];
  assign mode_vol = r_regs[24];

endmodule

// File: tb/tb_sid_regfile_8580.sv
// Scoreboard bench for sid_regfile_8580: the driver predicts each cycle's
// outcome from a byte-array model and queues it; the monitor compares.
module tb_sid_regfile_8580;

  localparam int DECAY = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce_1m = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic [23:0] freq_lo, freq_hi, pw_lo, pw_hi, control, att_dec, sus_rel;
  logic [7:0]  fc_lo, fc_hi, res_filt, mode_vol;
  logic [7:0]  pot_x = '0, pot_y = '0, osc3 = '0, env3 = '0;

  sid_regfile_8580 #(.DECAY_CYCLES(20'(DECAY))) dut (
    .clock(clock), .reset(reset), .ce_1m(ce_1m), .cs(cs), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .freq_lo(freq_lo), .freq_hi(freq_hi), .pw_lo(pw_lo), .pw_hi(pw_hi),
    .control(control), .att_dec(att_dec), .sus_rel(sus_rel),
    .fc_lo(fc_lo), .fc_hi(fc_hi), .res_filt(res_filt), .mode_vol(mode_vol),
    .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3), .env3(env3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         is_read;
    logic [7:0]   data;
    logic [199:0] regs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [7:0] m_mem [0:24];
  logic [7:0] m_latch;
  logic [7:0] m_dout;
  int         m_ticks;  // ce_1m ticks since the last bus refresh

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Register outputs as one vector: seven 24-bit voice fields then four
  // filter bytes; field k / voice v comes from offset 7v+k.
  function automatic logic [199:0] model_regs();
    logic [199:0] r;
    r = '0;
    for (int k = 0; k < 7; k++)
      for (int v = 0; v < 3; v++)
        r[176 - 24*k + 8*v +: 8] = m_mem[7*v + k];
    for (int k = 0; k < 4; k++)
      r[24 - 8*k +: 8] = m_mem[21 + k];
    return r;
  endfunction

  function automatic logic [7:0] live_value(input logic [4:0] a);
    case (a)
      5'h19:   return pot_x;
      5'h1A:   return pot_y;
      5'h1B:   return osc3;
      default: return env3;
    endcase
  endfunction

  // One access cycle: drive, predict, queue the expectation.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [4:0] a, input logic [7:0] d, input logic t);
    exp_t e;
    @(negedge clock); #1;
    reset = r; cs = c; we = w; addr = a; data_in = d; ce_1m = t;
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_latch = 8'h00; m_ticks = 0; m_dout = 8'h00;
    end else if (c && w) begin
      if (a <= 5'd24) begin
        if (a < 5'd21 && (int'(a) % 7) == 3) m_mem[a] = d & 8'h0F;
        else if (a == 5'd21)                 m_mem[a] = d & 8'h07;
        else                                 m_mem[a] = d;
      end
      m_latch = d; m_ticks = 0;
    end else if (c && a >= 5'h19 && a <= 5'h1C) begin
      m_dout = live_value(a); m_latch = m_dout; m_ticks = 0;
    end else begin
      // The latch reads as 0 once more than DECAY ticks have gone by.
      if (c) m_dout = (m_ticks > DECAY) ? 8'h00 : m_latch;
      if (t) m_ticks++;
    end
    e.is_read = r || (c && !w);
    e.data    = m_dout;
    e.regs    = model_regs();
    exp_q.push_back(e);
    @(posedge clock); #1;
    reset = 1'b0; cs = 1'b0; we = 1'b0; ce_1m = 1'b0;
  endtask

  // Monitor: each queued cycle's result is visible by the following negedge.
  initial begin
    exp_t e;
    logic [199:0] act;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {freq_lo, freq_hi, pw_lo, pw_hi, control, att_dec, sus_rel,
               fc_lo, fc_hi, res_filt, mode_vol};
        n_checks++;
        if (act === e.regs) n_pass++;
        else $display("FAIL regs: got 0x%0h, expected 0x%0h", act, e.regs);
        if (e.is_read) begin
          n_checks++;
          if (data_out === e.data) n_pass++;
          else $display("FAIL data_out: got 0x%0h, expected 0x%0h", data_out, e.data);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 5'h00, 8'h00, 0);
    step(1, 1, 1, 5'h04, 8'hEE, 1);  // reset wins over a write
    step(0, 1, 0, 5'h00, 8'h00, 0);
    step(0, 1, 0, 5'h18, 8'h00, 0);
    @(negedge clock); check("rd_0x18_after_reset", data_out, 8'h00);

    // Masked pw_hi writes and latch readback of a write-only register
    step(0, 1, 1, 5'h03, 8'hAB, 0);
    step(0, 1, 1, 5'h0A, 8'hFF, 0);
    @(negedge clock); check("pw_hi", pw_hi, 24'h000F0B);
    step(0, 1, 0, 5'h03, 8'h00, 0);
    @(negedge clock); check("rd_0x03_latch", data_out, 8'hFF);

    step(0, 1, 1, 5'h15, 8'hFF, 0);
    step(0, 1, 1, 5'h12, 8'h41, 0);
    @(negedge clock);
    check("fc_lo", fc_lo, 8'h07);
    check("control", control, 24'h410000);

    // Read-only read refreshes the latch
    osc3 = 8'h5A;
    step(0, 1, 0, 5'h1B, 8'h00, 0);
    @(negedge clock); check("rd_osc3", data_out, 8'h5A);
    step(0, 1, 0, 5'h05, 8'h00, 0);
    @(negedge clock); check("rd_0x05_refreshed", data_out, 8'h5A);

    // Decay after an unmapped write
    step(0, 1, 1, 5'h1E, 8'h77, 0);
    repeat (9) step(0, 0, 0, 5'h00, 8'h00, 1);
    step(0, 1, 0, 5'h00, 8'h00, 0);
    @(negedge clock); check("decay_before", data_out, 8'h77);
    repeat (2) step(0, 0, 0, 5'h00, 8'h00, 1);
    step(0, 1, 0, 5'h00, 8'h00, 0);
    @(negedge clock); check("decay_after", data_out, 8'h00);

    // Write coinciding with the 10th tick restarts the count
    step(0, 1, 1, 5'h1D, 8'h77, 0);
    repeat (9) step(0, 0, 0, 5'h00, 8'h00, 1);
    step(0, 1, 1, 5'h1F, 8'h33, 1);
    repeat (9) step(0, 0, 0, 5'h00, 8'h00, 1);
    step(0, 1, 0, 5'h07, 8'h00, 0);
    @(negedge clock); check("restart_held", data_out, 8'h33);
    repeat (2) step(0, 0, 0, 5'h00, 8'h00, 1);
    step(0, 1, 0, 5'h07, 8'h00, 0);
    @(negedge clock); check("restart_cleared", data_out, 8'h00);

    // Randomized traffic: back-to-back accesses, overlapping ticks, resets
    for (int i = 0; i < 3000; i++) begin
      pot_x = 8'($urandom); pot_y = 8'($urandom);
      osc3  = 8'($urandom); env3  = 8'($urandom);
      step(($urandom % 200) == 0, ($urandom % 3) != 0, ($urandom % 2) == 0,
           5'($urandom), 8'($urandom), ($urandom % 3) == 0);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
